// File: rtl/monmult_arb_pkg.sv
// Shared types for the Montgomery-multiplier arbiter.
// State encoding, default operand width and requester id.
package monmult_arb_pkg;

  localparam int MMARB_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } mmarb_state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/monmult_arbiter_rr_pick2.sv
// Two-way round-robin picker: a tie goes to the
// requester that was not granted last time.
module rr_pick2
  import monmult_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       grant_vld
);

  always_comb begin
    grant = 1'b0;
    unique case (valid)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  assign grant_vld = |valid;

endmodule

// File: rtl/monmult_arbiter.sv
// Two-requester arbiter in front of one shared Montgomery multiplier.
// Optional watchdog: define MMARB_TIMEOUT_EN.
module monmult_arbiter
  import monmult_arb_pkg::*;
#(
  parameter int WIDTH          = MMARB_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             pclk,
  input  logic             nreset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_m,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_m,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_p,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_p,
  output logic             mm_go,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  input  logic [WIDTH-1:0] mm_p,
  input  logic             mm_ready,
  output logic             busy,
  output logic             grant_id,
  output logic             err
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] DONE  = ST_DONE;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a, op_b, op_m;
  logic [WIDTH-1:0] p0_q, p1_q;
  logic [WIDTH-1:0] res;
  req_id_t          gid_q, last_q, pick;
  logic             pick_vld, accept, finish, to_hit;

  rr_pick2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_q),
    .grant      (pick),
    .grant_vld  (pick_vld)
  );

  assign accept     = (state == IDLE) && pick_vld;
  assign req0_ready = accept && (pick == 1'b0);
  assign req1_ready = accept && (pick == 1'b1);

`ifdef MMARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign to_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (!nreset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        wd_q <= '0;
      else if (state == ISSUE)
        wd_q <= wd_q + 1'b1;
      if (state == ISSUE && !mm_ready && to_hit)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // A ready product wins over a simultaneous watchdog expiry.
  assign finish = mm_ready || to_hit;
  assign res    = mm_ready ? mm_p : '0;

  always_ff @(posedge pclk) begin
    if (!nreset) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_m   <= '0;
      p0_q   <= '0;
      p1_q   <= '0;
      gid_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= pick ? req1_a : req0_a;
            op_b   <= pick ? req1_b : req0_b;
            op_m   <= pick ? req1_m : req0_m;
            gid_q  <= pick;
            last_q <= pick;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (finish) begin
            if (gid_q)
              p1_q <= res;
            else
              p0_q <= res;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mm_go      = (state == ISSUE);
  assign mm_a       = op_a;
  assign mm_b       = op_b;
  assign mm_m       = op_m;
  assign busy       = (state != IDLE);
  assign grant_id   = gid_q;
  assign rsp0_valid = (state == DONE) && !gid_q;
  assign rsp1_valid = (state == DONE) && gid_q;
  assign rsp0_p     = p0_q;
  assign rsp1_p     = p1_q;

endmodule

// File: tb/tb_monmult_arbiter.sv
// Bench for monmult_arbiter: vector table, corner sequences and
// random traffic checked against a job-timeline reference model.
module tb_monmult_arbiter;
  import monmult_arb_pkg::*;

  localparam int W  = 64;
  localparam int TO = 20;

  typedef struct {
    bit         v0, v1;
    logic [W-1:0] a0, b0, m0, a1, b1, m1;
    bit         exp_id;
    logic [W-1:0] exp_p;
  } tv_t;

  logic         pclk = 1'b0;
  logic         nreset = 1'b0;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req0_m, req1_a, req1_b, req1_m;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_p, rsp1_p;
  logic         mm_go, mm_ready, busy, grant_id, err;
  logic [W-1:0] mm_a, mm_b, mm_m, mm_p;

  always #5 pclk = ~pclk;

  monmult_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .nreset(nreset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
    .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p),
    .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p),
    .mm_go(mm_go), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_p(mm_p), .mm_ready(mm_ready),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  // Multiplier stand-in: 0 = 10-cycle latency, 1 = never ready, 2 = always ready
  int mode = 0;
  int lat_cnt = 0;
  always @(posedge pclk) lat_cnt <= mm_go ? lat_cnt + 1 : 0;
  assign mm_ready = (mode == 2) || (mode == 0 && mm_go && lat_cnt == 10);
  assign mm_p     = mm_ready ? mm_a + mm_b : '1;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  // Reference model: a job accepted at cycle c issues c+1.., responds at rsp_c
  bit           live = 0, e_to = 0, rsp_id = 0;
  int           acc_c = -100, rsp_c = -100;
  logic [W-1:0] rsp_v, ea, eb, em, ep0, ep1;
  bit           egid, elast, eerr;

  int           obs_n[2];
  int           obs_c[2];
  logic [W-1:0] obs_p[2];
  int           grants[$];
  int           go_low = 0;
  bit           go_seen = 0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit free, acc, g;
    @(negedge pclk);
    if (!nreset) begin
      live = 0; ea = '0; eb = '0; em = '0; ep0 = '0; ep1 = '0;
      egid = 0; elast = 1; eerr = 0; go_seen = 0; go_low = 0;
    end else begin
      free = !live || cyc > rsp_c;
      acc  = free && (req0_valid || req1_valid);
      g    = (req0_valid && req1_valid) ? !elast : req1_valid;
      if (live && cyc == rsp_c) begin
        if (rsp_id) ep1 = rsp_v; else ep0 = rsp_v;
        if (e_to) eerr = 1;
      end
      chk("req0_ready", req0_ready, acc && !g);
      chk("req1_ready", req1_ready, acc && g);
      chk("mm_go", mm_go, live && cyc > acc_c && cyc < rsp_c);
      chk("busy", busy, live && cyc > acc_c && cyc <= rsp_c);
      chk("rsp0_valid", rsp0_valid, live && cyc == rsp_c && !rsp_id);
      chk("rsp1_valid", rsp1_valid, live && cyc == rsp_c && rsp_id);
      chk("rsp0_p", rsp0_p, ep0);
      chk("rsp1_p", rsp1_p, ep1);
      chk("grant_id", grant_id, egid);
      chk("mm_a", mm_a, ea);
      chk("mm_b", mm_b, eb);
      chk("mm_m", mm_m, em);
      chk("err", err, eerr);
      if (rsp0_valid) begin obs_n[0]++; obs_c[0] = cyc; obs_p[0] = rsp0_p; end
      if (rsp1_valid) begin obs_n[1]++; obs_c[1] = cyc; obs_p[1] = rsp1_p; end
      if (req0_valid && req0_ready) grants.push_back(0);
      if (req1_valid && req1_ready) grants.push_back(1);
      if (mm_go && go_low > 0 && go_seen) chk("go_gap", go_low >= 2, 1);
      if (mm_go) begin go_low = 0; go_seen = 1; end
      else go_low++;
      if (acc) begin
        live = 1; acc_c = cyc; egid = g; elast = g; rsp_id = g;
        ea = g ? req1_a : req0_a;
        eb = g ? req1_b : req0_b;
        em = g ? req1_m : req0_m;
        e_to  = (mode == 1);
        rsp_c = cyc + (e_to ? TO + 1 : 12);
        rsp_v = e_to ? '0 : ea + eb;
      end
    end
    @(posedge pclk);
    cyc++;
    #1;
  endtask

  task automatic wait_free();
    int guard = 0;
    while (live && cyc <= rsp_c && guard < 100) begin step(); guard++; end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic run_job(input tv_t v, input int lat);
    int guard = 0, n, t;
    bit id;
    wait_free();
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_m = v.m0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_m = v.m1;
    n = obs_n[0] + obs_n[1];
    t = cyc;
    step();
    idle_inputs();
    while (obs_n[0] + obs_n[1] == n && guard < 60) begin step(); guard++; end
    if (obs_n[0] + obs_n[1] == n) begin
      n_chk++; n_fail++;
      $display("FAIL job_no_rsp cyc=%0d got=none exp=response", cyc);
    end else begin
      id = (obs_c[1] == cyc - 1) && (obs_n[1] > 0);
      chk("job_id", id, v.exp_id);
      chk("job_p", obs_p[id], v.exp_p);
      chk("job_lat", obs_c[id] - t, lat);
    end
  endtask

  tv_t tab[6];
  int  n0;

  initial begin
    idle_inputs();
    req0_a = 0; req0_b = 0; req0_m = 0;
    req1_a = 0; req1_b = 0; req1_m = 0;
    obs_n[0] = 0; obs_n[1] = 0;
    obs_c[0] = -1; obs_c[1] = -1;
    step(); step();
    nreset = 1;

    tab[0] = '{1, 0, 5, 7, 64'hFFFF_FFFF_FFFF_FFC5, 0, 0, 0, 0, 12};
    tab[1] = '{1, 1, 100, 1, 3, 20, 22, 7, 1, 42};
    tab[2] = '{1, 1, 3, 4, 5, 9, 9, 5, 0, 7};
    tab[3] = '{0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 9, 1, 1};
    tab[4] = '{1, 1, 64'h1234, 1, 17, 8, 8, 3, 0, 64'h1235};
    tab[5] = '{1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1,
               0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) run_job(tab[i], 12);

    // operands changed right after acceptance must not leak into the job
    wait_free();
    req1_valid = 1; req1_a = 11; req1_b = 22; req1_m = 33;
    step();
    req1_valid = 0; req1_a = 999; req1_b = 777; req1_m = 555;
    step(); step();
    chk("hold_mm_a", mm_a, 11);
    chk("hold_mm_b", mm_b, 22);
    wait_free();
    chk("hold_rsp1_p", rsp1_p, 33);

    // continuous contention after reset alternates 0,1,0,1
    nreset = 0; step(); nreset = 1;
    grants.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 200 && grants.size() < 4; i++) begin
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      step();
    end
    idle_inputs();
    wait_free();
    if (grants.size() < 4) begin
      n_chk++; n_fail++;
      $display("FAIL rr_count got=%0d exp=4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) chk("rr_order", grants[i], i % 2);
    end

    // reset in the fifth ISSUE cycle drops the job silently
    wait_free();
    req0_valid = 1; req0_a = 40; req0_b = 2; req0_m = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    n0 = obs_n[0] + obs_n[1];
    nreset = 0; step(); nreset = 1;
    chk("rst_mm_go", mm_go, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 15; i++) step();
    chk("rst_no_rsp", obs_n[0] + obs_n[1], n0);
    run_job('{1, 0, 6, 9, 1, 0, 0, 0, 0, 15}, 12);

    // mm_ready high while idle never produces a response
    mode = 2;
    n0 = obs_n[0] + obs_n[1];
    for (int i = 0; i < 50; i++) step();
    chk("idle_ready_rsp", obs_n[0] + obs_n[1], n0);
    chk("idle_ready_busy", busy, 0);
    mode = 0;

    // random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 2) == 0);
      req1_valid = ($urandom_range(0, 2) == 0);
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req0_m = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      req1_m = {$urandom, $urandom};
      step();
    end
    idle_inputs();
    wait_free();

`ifdef MMARB_TIMEOUT_EN
    mode = 1;
    run_job('{1, 0, 3, 4, 5, 0, 0, 0, 0, 0}, TO + 1);
    mode = 0;
    chk("to_err", err, 1);
    for (int i = 0; i < 5; i++) step();
    chk("to_err_sticky", err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/monmult_arbiter.md
MONMULT_ARBITER -- requirements
Module: monmult_arbiter

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width; matches the RSA key length.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles; used only when MMARB_TIMEOUT_EN is defined.
REQ-003 pclk  in  1  clock; all state updates on the rising edge.
REQ-004 nreset  in  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester N has a multiply job pending.
REQ-006 req0_ready / req1_ready  out  1  job from requester N is accepted this cycle.
REQ-007 req0_a/_b/_m, req1_a/_b/_m  in  WIDTH  operands A, B and modulus M from requester N.
REQ-008 rsp0_valid / rsp1_valid  out  1  one-cycle pulse; result is ready for requester N.
REQ-009 rsp0_p / rsp1_p  out  WIDTH  result for requester N; holds until that requester's next response.
REQ-010 mm_go  out  1  start/hold strobe to the shared Montgomery multiplier.
REQ-011 mm_a, mm_b, mm_m  out  WIDTH  operands to the multiplier.
REQ-012 mm_p  in  WIDTH  multiplier product.
REQ-013 mm_ready  in  1  multiplier product is valid.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 grant_id  out  1  requester owning the current or last job.
REQ-016 err  out  1  sticky timeout flag; tied 0 when the timeout feature is compiled out.

Function
REQ-017 FSM states: IDLE, ISSUE, DONE.
REQ-018 In IDLE, acceptance occurs when reqN_valid && reqN_ready; reqN_ready is combinational and is high only in IDLE, only for the requester selected by arbitration.
REQ-019 Arbitration: if one requester is valid, grant it; if both are valid, grant the requester not granted last (round-robin); last_grant resets to 1, so req0 wins the first tie.
REQ-020 On acceptance, the arbiter registers the requester's A, B and M into internal registers, sets grant_id, and moves to ISSUE; later changes on the req inputs shall not affect the job.
REQ-021 ISSUE: mm_go=1 and mm_a/mm_b/mm_m come from the registered copies; on the first cycle mm_ready is sampled high, capture mm_p into rspN_p (N=grant_id) and move to DONE.
REQ-022 DONE: mm_go=0 and rspN_valid=1 for exactly one cycle; next state is IDLE.
REQ-023 Latency: accept at cycle T gives mm_go high at T+1; mm_ready sampled at cycle R gives rsp valid at R+1; earliest next acceptance is at R+2.
REQ-024 mm_go shall be low for at least 2 cycles between jobs, so the multiplier rearms.
REQ-025 mm_ready shall be ignored in IDLE and DONE; it shall never cause a response.
REQ-026 Responses have no back-pressure; a requester shall sample rspN_p while rspN_valid is high.
REQ-027 mm_a/mm_b/mm_m shall hold their last values outside ISSUE; mm_go shall be 0 outside ISSUE.

Reset
REQ-028 While nreset=0, on each clock: state=IDLE, mm_go=0, rsp*_valid=0, rsp*_p=0, operand registers=0, grant_id=0, last_grant=1, err=0, watchdog=0.
REQ-029 Reset mid-job shall drop the job with no response; busy=0 on the first cycle after reset.

Configuration
REQ-030 With MMARB_TIMEOUT_EN defined, a watchdog counts ISSUE cycles; when it reaches TIMEOUT_CYCLES with no mm_ready, the FSM moves to DONE, the response carries rspN_p=0, and err is set (sticky until reset). The watchdog clears on entry to ISSUE.
REQ-031 Without MMARB_TIMEOUT_EN, ISSUE waits indefinitely, no watchdog logic exists, and err=0.

Structure
REQ-032 Shared package monmult_arb_pkg holds the state enum, the default WIDTH, and the requester-id type.
REQ-033 The two-way round-robin picker shall be a sub-module named rr_pick2 (inputs: valid[1:0], last_grant; output: grant index and grant-valid).

Verification
REQ-034 Model multiplier: latency 10 cycles, P=A+B. Stimulus: req0 only, a=5, b=7, m=0xFFFFFFFFFFFFFFC5, accepted at T. Response: mm_go high at T+1; rsp0_valid pulse at T+12 with rsp0_p=12; rsp1_valid stays 0.
REQ-035 Both requesters valid continuously for 4 jobs -> grants alternate 0,1,0,1; each rsp goes to the granted requester; mm_go low for at least 2 cycles between jobs.
REQ-036 req1 operands changed the cycle after acceptance -> mm_a/mm_b keep the accepted values; rsp1_p equals the sum of the original operands.
REQ-037 nreset pulsed low at the 5th ISSUE cycle -> mm_go=0 and busy=0 on the next cycle; no rsp pulse; a new req0 job then completes normally.
REQ-038 With MMARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, model never asserts ready -> rsp0_valid pulses with rsp0_p=0 after 20 ISSUE cycles; err=1 and stays 1.
REQ-039 mm_ready held high while IDLE for 50 cycles -> no rsp*_valid pulses and busy=0.
